// File: rtl/reg_bank_arbiter.sv
// Shared register bank written by NREQ requesters under round-robin arbitration,
// with a registered one-hot write acknowledge and a registered read port.
module reg_bank_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2,
    localparam int SRC_W = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   wr_addr,
    input  logic [NREQ*DATA_W-1:0]   wr_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     wr_valid,
    output logic [SRC_W-1:0]         wr_src,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] bank_q [NREGS];
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              wr_valid_q, wr_valid_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] rd_q;

    logic [NREQ-1:0]   elig;
    logic              found;
    logic [SRC_W-1:0]  win;
    logic [SRC_W:0]    sum;
    logic [SRC_W-1:0]  idx;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              wa_ok;
    logic              ra_ok;

    always_comb begin
        // A requester granted at the last edge is masked so it cannot win twice in a row.
        elig  = req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(NREQ)) begin
                sum = sum - (SRC_W+1)'(NREQ);
            end
            idx = sum[SRC_W-1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        wa    = wr_addr[win*ADDR_W +: ADDR_W];
        wd    = wr_data[win*DATA_W +: DATA_W];
        wa_ok = {1'b0, wa} < (ADDR_W+1)'(NREGS);
        ra_ok = {1'b0, rd_addr} < (ADDR_W+1)'(NREGS);

        gnt_d      = found ? (NREQ'(1) << win) : '0;
        wr_valid_d = found;
        src_d      = found ? win : src_q;
        ptr_d      = ptr_q;
        if (found) begin
            ptr_d = (win == SRC_W'(NREQ-1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                bank_q[r] <= '0;
            end
            gnt_q      <= '0;
            wr_valid_q <= 1'b0;
            src_q      <= '0;
            ptr_q      <= '0;
            rd_q       <= '0;
        end else begin
            gnt_q      <= gnt_d;
            wr_valid_q <= wr_valid_d;
            src_q      <= src_d;
            ptr_q      <= ptr_d;
            // Out-of-range writes are dropped but still acknowledged.
            if (found && wa_ok) begin
                bank_q[wa] <= wd;
            end
            rd_q <= ra_ok ? bank_q[rd_addr] : '0;
        end
    end

    assign gnt      = gnt_q;
    assign wr_valid = wr_valid_q;
    assign wr_src   = src_q;
    assign rd_data  = rd_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: stimulus queues expected grants and read
// data, a monitor compares them whenever the DUT presents a result.
module tb_reg_bank_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int NREGS  = 4;
    localparam int ADDR_W = 2;
    localparam int SRC_W  = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] wr_addr;
    logic [NREQ*DATA_W-1:0] wr_data;
    logic [NREQ-1:0]        gnt;
    logic                   wr_valid;
    logic [SRC_W-1:0]       wr_src;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_data;

    reg_bank_arbiter #(
        .NREQ  (NREQ),
        .DATA_W(DATA_W),
        .NREGS (NREGS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .wr_valid(wr_valid),
        .wr_src  (wr_src),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   gnt_exp[$];
    int   rd_exp[$];
    logic rd_chk = 1'b0;
    logic mon_rd_pend;
    int   mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_wr(input int i, input int a, input int d);
        wr_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        wr_data[i*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic rd(input int a, input int e);
        rd_addr = ADDR_W'(a);
        rd_exp.push_back(e);
        rd_chk = 1'b1;
        step();
        rd_chk = 1'b0;
    endtask

    // Monitor: every cycle, compare grant outputs and any requested read result.
    initial begin
        forever begin
            @(posedge clk);
            mon_rd_pend = rd_chk;
            @(negedge clk);
            if (wr_valid === 1'b1) begin
                if (gnt_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_grant: got gnt=0x%0h, expected no grant at %0t", gnt, $time);
                end else begin
                    mon_e = gnt_exp.pop_front();
                    check("wr_src", 32'(wr_src), 32'(mon_e));
                    check("gnt_onehot", 32'(gnt), 32'(1) << mon_e);
                end
            end else begin
                check("gnt_idle", 32'(gnt), 32'd0);
            end
            if (mon_rd_pend) begin
                if (rd_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_underflow: got rd_data=0x%0h, expected no read at %0t", rd_data, $time);
                end else begin
                    mon_e = rd_exp.pop_front();
                    check("rd_data", 32'(rd_data), 32'(mon_e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        req     = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(wr_valid), 32'd0);
        check("rst_src", 32'(wr_src), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        reset = 1'b0;

        // Idle after reset: every address reads zero, no grants.
        rd(0, 0); rd(1, 0); rd(2, 0); rd(3, 0); rd(0, 0);

        // Single write from requester 0, then read back.
        set_wr(0, 2, 'hAA);
        req = 4'b0001;
        gnt_exp.push_back(0);
        step();
        req = '0;
        rd(2, 'hAA);

        // Full contention: ptr is 1 after the single write.
        for (int i = 0; i < NREQ; i++) set_wr(i, i, 'h10 + i);
        req = 4'b1111;
        foreach (gnt_exp[i]) begin end
        gnt_exp.push_back(1); gnt_exp.push_back(2); gnt_exp.push_back(3); gnt_exp.push_back(0);
        gnt_exp.push_back(1); gnt_exp.push_back(2); gnt_exp.push_back(3); gnt_exp.push_back(0);
        repeat (8) step();
        req = '0;
        rd(0, 'h10); rd(1, 'h11); rd(2, 'h12); rd(3, 'h13);

        // Pointer rotation: grant 2, then 0101 -> 0 (search 3,0), then 2.
        set_wr(0, 0, 'h30);
        set_wr(2, 2, 'h32);
        req = 4'b0100;
        gnt_exp.push_back(2);
        step();
        req = 4'b0101;
        gnt_exp.push_back(0);
        step();
        gnt_exp.push_back(2);
        step();
        req = '0;
        rd(0, 'h30); rd(2, 'h32);

        // Collision on address 1 with read-during-write; ptr is 3.
        set_wr(0, 1, 'h55);
        set_wr(1, 1, 'h66);
        rd_addr = 2'd1;
        rd_chk  = 1'b1;
        req = 4'b0011;
        gnt_exp.push_back(0);
        rd_exp.push_back('h11);
        step();
        req = 4'b0010;
        gnt_exp.push_back(1);
        rd_exp.push_back('h55);
        step();
        req = '0;
        rd_exp.push_back('h66);
        step();
        rd_chk = 1'b0;

        // Asynchronous reset mid-burst; ptr is 2.
        for (int i = 0; i < NREQ; i++) set_wr(i, i, 'h40 + i);
        req = 4'b1111;
        gnt_exp.push_back(2);
        step();
        gnt_exp.push_back(3);
        step();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_valid", 32'(wr_valid), 32'd0);
        check("arst_src", 32'(wr_src), 32'd0);
        check("arst_rd", 32'(rd_data), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        gnt_exp.push_back(0);
        step();
        req = '0;
        rd(0, 'h40); rd(1, 0); rd(2, 0); rd(3, 0);

        repeat (2) step();
        check("gnt_queue_drained", 32'(gnt_exp.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
